pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (MAIN plus SKID) with a valid/ready handshake.
// All state changes happen on the falling edge of Clk. In_Ready depends only on
// registered state and Reset, so there is no combinational path from Out_Ready or
// In_Valid. Flush squashes every held entry. StallCount is a saturating count of
// back-pressure cycles, and only Reset clears it.
module pipe_stage_reg #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 101,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [CNT_W-1:0]  StallCount
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              in_xfer, out_xfer;
  logic              load_main, load_skid, move_skid;

  // Handshake qualifiers, computed from registered state so that readiness stays path-free.
  assign in_xfer  = In_Valid && (state != FULL);
  assign out_xfer = Out_Ready && (state != EMPTY);

  // State register, updated on the falling edge.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Next-state logic and datapath load strobes. Flush has priority over every transfer.
  // NOTE: each output gets a default first, so no path through this block can infer a latch.
  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (Flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            load_main = 1'b1;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_main = 1'b1;
          end else if (in_xfer) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            move_skid = 1'b1;
            state_nxt = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Outputs. Readiness is gated by Reset, and a bubble shows an all-zero control field.
  always_comb begin
    In_Ready  = !Reset && (state != FULL);
    Out_Valid = (state != EMPTY);
    Out_Ctrl  = Out_Valid ? main_ctrl : '0;
    Out_Data  = main_data;
  end

  // MAIN and SKID entry storage. A flush zeroes the control fields, and the payload keeps its value.
  // NOTE: both entries are reset, so Out_Data reads zero as soon as Reset asserts.
  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (Flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main) begin
        main_ctrl <= In_Ctrl;
        main_data <= In_Data;
      end else if (move_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= In_Ctrl;
        skid_data <= In_Data;
      end
    end
  end

  // Saturating back-pressure counter. Flush has no effect on it.
  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) begin
      StallCount <= '0;
    end else if ((state != EMPTY) && !Out_Ready && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
